// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, filler words and the fetch-stage state type.
package mips_pkg;

    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: branch redirect, stall hold, local jump, sequential,
// plus range/alignment fault detection on the address that would actually be loaded.
module fetch_next_pc
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = 128
) (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        is_jump,
    output logic        fault
);

    localparam logic [29:0] LAST_WORD = 30'(IMEM_SIZE - 1);

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic        load;

    always_comb begin
        pc_plus4    = pc + 32'd4;
        is_jump     = (instr[31:26] == OP_J);
        jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
        load        = branch_taken || !stall;

        if (branch_taken) begin
            next_pc = branch_target;
        end else if (stall) begin
            next_pc = pc;
        end else if (is_jump) begin
            next_pc = jump_target;
        end else begin
            next_pc = pc_plus4;
        end

        // A held PC is never re-checked, so a stall cannot raise a fault.
        fault = load && ((next_pc[1:0] != 2'b00) || (next_pc[31:2] > LAST_WORD));
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and RUN/HALT control.
// State | meaning:  RUN - fetching normally;  HALT - fault seen, everything frozen until reset.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] next_pc;
    logic        is_jump;
    logic        fault;
    logic [31:0] pc_plus4;

    fetch_next_pc #(
        .IMEM_SIZE (IMEM_SIZE)
    ) u_next_pc (
        .pc            (pc_q),
        .instr         (instr_in),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .is_jump       (is_jump),
        .fault         (fault)
    );

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && fault) begin
            state_d = HALT;
        end
    end

    always_comb begin
        halted      = (state_q == HALT);
        if_id_valid = valid_q && (state_q == RUN);
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;

        if (state_q == RUN) begin
            if (branch_taken) begin
                valid_d = 1'b0;
                instr_d = NOP_WORD;
            end else if (!stall) begin
                instr_d = instr_in;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                count_d = count_q + 32'd1;
            end

            // The faulting cycle still captures its word, but it never reaches decode as valid.
            if (fault) begin
                valid_d = 1'b0;
            end else begin
                pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        if (!reset && state_q == RUN && is_jump && !branch_taken && !stall && !fault) begin
            assert (next_pc == {pc_plus4[31:28], instr_in[25:0], 2'b00});
        end
    end

    assign pc_out         = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] imem [0:127];
    logic [31:0] prog [0:5];

    int n_checks;
    int n_fail;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_SIZE (128)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .instr_in       (instr_in),
        .pc_out         (pc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_in = (pc_out[31:2] < 30'd128) ? imem[pc_out[8:2]] : 32'h0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, 32'h0); end
        n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h expected %h", if_id_pc_plus4, 32'h0); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
        reset = 1'b0;
    endtask

    task automatic test_sequential_jump_branch();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (pc_out !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, pc_out, 32'(4 * k)); end
            if (k > 0) begin
                n_checks++; if (if_id_instr !== prog[k-1]) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, if_id_instr, prog[k-1]); end
                n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, if_id_valid); end
                n_checks++; if (fetch_count !== 32'(k)) begin n_fail++; $display("FAIL seq_count[%0d]: got %0d expected %0d", k, fetch_count, k); end
            end
            tick();
        end
        n_checks++; if (pc_out !== 32'h14) begin n_fail++; $display("FAIL seq_pc_end: got %h expected %h", pc_out, 32'h14); end
        n_checks++; if (if_id_instr !== 32'h2031_0099) begin n_fail++; $display("FAIL seq_instr_end: got %h expected %h", if_id_instr, 32'h2031_0099); end
        n_checks++; if (if_id_pc_plus4 !== 32'h14) begin n_fail++; $display("FAIL seq_pc4_end: got %h expected %h", if_id_pc_plus4, 32'h14); end
        n_checks++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL seq_count_end: got %0d expected 5", fetch_count); end

        tick();
        n_checks++; if (pc_out !== 32'h20) begin n_fail++; $display("FAIL jump_pc: got %h expected %h", pc_out, 32'h20); end
        n_checks++; if (if_id_instr !== 32'h0800_0008) begin n_fail++; $display("FAIL jump_instr: got %h expected %h", if_id_instr, 32'h0800_0008); end
        n_checks++; if (if_id_pc_plus4 !== 32'h18) begin n_fail++; $display("FAIL jump_pc4: got %h expected %h", if_id_pc_plus4, 32'h18); end
        n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL jump_valid: got %b expected 1", if_id_valid); end
        n_checks++; if (fetch_count !== 32'd6) begin n_fail++; $display("FAIL jump_count: got %0d expected 6", fetch_count); end

        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h28;
        tick();
        branch_taken  = 1'b0;
        stall         = 1'b0;
        n_checks++; if (pc_out !== 32'h28) begin n_fail++; $display("FAIL br_pc: got %h expected %h", pc_out, 32'h28); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b expected 0", if_id_valid); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL br_instr: got %h expected %h", if_id_instr, 32'h0); end
        n_checks++; if (fetch_count !== 32'd6) begin n_fail++; $display("FAIL br_count: got %0d expected 6", fetch_count); end

        tick();
        n_checks++; if (pc_out !== 32'h2C) begin n_fail++; $display("FAIL br_after_pc: got %h expected %h", pc_out, 32'h2C); end
        n_checks++; if (if_id_instr !== 32'h2000_000A) begin n_fail++; $display("FAIL br_after_instr: got %h expected %h", if_id_instr, 32'h2000_000A); end
        n_checks++; if (if_id_pc_plus4 !== 32'h2C) begin n_fail++; $display("FAIL br_after_pc4: got %h expected %h", if_id_pc_plus4, 32'h2C); end
        n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL br_after_valid: got %b expected 1", if_id_valid); end
        n_checks++; if (fetch_count !== 32'd7) begin n_fail++; $display("FAIL br_after_count: got %0d expected 7", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        reset = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", k, pc_out, 32'h8); end
            n_checks++; if (if_id_instr !== 32'h0064_2820) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h expected %h", k, if_id_instr, 32'h0064_2820); end
            n_checks++; if (if_id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL stall_pc4[%0d]: got %h expected %h", k, if_id_pc_plus4, 32'h8); end
            n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, if_id_valid); end
            n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d expected 2", k, fetch_count); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL unstall_pc: got %h expected %h", pc_out, 32'hC); end
        n_checks++; if (if_id_instr !== 32'hAE01_0000) begin n_fail++; $display("FAIL unstall_instr: got %h expected %h", if_id_instr, 32'hAE01_0000); end
        n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL unstall_count: got %0d expected 3", fetch_count); end
    endtask

    task automatic test_fault(input logic [31:0] tgt);
        do_reset();
        reset = 1'b0;
        tick();
        branch_taken  = 1'b1;
        branch_target = tgt;
        tick();
        branch_taken  = 1'b0;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL fault_halted(%h): got %b expected 1", tgt, halted); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL fault_valid(%h): got %b expected 0", tgt, if_id_valid); end
        n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL fault_pc(%h): got %h expected %h", tgt, pc_out, 32'h4); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL fault_instr(%h): got %h expected %h", tgt, if_id_instr, 32'h0); end
        for (int k = 0; k < 3; k++) begin
            branch_taken  = (k != 1);
            stall         = (k == 1);
            branch_target = 32'h40;
            tick();
            n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h expected %h", k, pc_out, 32'h4); end
            n_checks++; if (halted !== 1'b1 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_flags[%0d]: got halted=%b valid=%b expected 1/0", k, halted, if_id_valid); end
            n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL halt_count[%0d]: got %0d expected 1", k, fetch_count); end
        end
        branch_taken = 1'b0;
        stall        = 1'b0;
    endtask

    task automatic test_boundary();
        do_reset();
        reset = 1'b0;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h1FC;
        tick();
        branch_taken  = 1'b0;
        n_checks++; if (pc_out !== 32'h1FC || halted !== 1'b0) begin n_fail++; $display("FAIL last_word: got pc=%h halted=%b expected 1fc/0", pc_out, halted); end
        tick();
        n_checks++; if (pc_out !== 32'h1FC) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", pc_out, 32'h1FC); end
        n_checks++; if (halted !== 1'b1 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_flags: got halted=%b valid=%b expected 1/0", halted, if_id_valid); end
    endtask

    task automatic test_reset_mid();
        reset         = 1'b1;
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h28;
        tick();
        n_checks++; if (pc_out !== 32'h0 || halted !== 1'b0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got pc=%h halted=%b valid=%b expected 0/0/0", pc_out, halted, if_id_valid); end
        n_checks++; if (fetch_count !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL halt_reset_regs: got cnt=%0d instr=%h pc4=%h expected 0", fetch_count, if_id_instr, if_id_pc_plus4); end
        reset        = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick();
        n_checks++; if (pc_out !== 32'h4 || if_id_instr !== 32'h0001_1020 || if_id_valid !== 1'b1 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL restart: got pc=%h instr=%h valid=%b cnt=%0d expected 4/00011020/1/1", pc_out, if_id_instr, if_id_valid, fetch_count); end
        tick();
        tick();
        reset        = 1'b1;
        branch_taken = 1'b1;
        tick();
        n_checks++; if (pc_out !== 32'h0 || fetch_count !== 32'h0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got pc=%h cnt=%0d valid=%b expected 0/0/0", pc_out, fetch_count, if_id_valid); end
        reset        = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        for (int i = 0; i < 128; i++) imem[i] = 32'h2000_0000 | 32'(i);
        prog[0] = 32'h0001_1020;
        prog[1] = 32'h0064_2820;
        prog[2] = 32'hAE01_0000;
        prog[3] = 32'h8E04_0000;
        prog[4] = 32'h2031_0099;
        prog[5] = 32'h0800_0008;
        for (int i = 0; i < 6; i++) imem[i] = prog[i];

        test_reset();
        test_sequential_jump_branch();
        test_stall();
        test_fault(32'h202);
        test_fault(32'h200);
        test_boundary();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS core: owns the program counter, drives the instruction memory read address, and captures the returned word into the IF/ID pipeline register for decode. It resolves unconditional jumps (`j`) locally, accepts taken-branch redirects and stalls from downstream, and halts on an out-of-range or misaligned fetch address.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_SIZE`, 128, instruction memory depth in 32-bit words; legal fetch word index is 0..IMEM_SIZE-1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID contents this cycle.
- `branch_taken`  in  1  one-cycle redirect request from the branch-resolve stage.
- `branch_target`  in  32  byte address to fetch next when `branch_taken`=1.
- `instr_in`  in  32  word returned combinationally by instruction memory for `pc_out`.
- `pc_out`  out  32  current PC; drives instruction memory read address.
- `if_id_instr`  out  32  registered instruction for decode.
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  stage is in HALT.
- `fetch_count`  out  32  number of instructions loaded into IF/ID since reset.

## Operation
- States: RUN, HALT. Reset → RUN. RUN → HALT on fault. HALT exits only via `reset`.
- `pc_plus4` = `pc_out` + 32'd4, modulo 2^32.
- Jump detect: `instr_in[31:26]` == 6'b000010 → `jump_target` = {`pc_plus4[31:28]`, `instr_in[25:0]`, 2'b00}.
- Next-PC priority in RUN (highest first): `branch_taken` → `branch_target`; `stall` → hold; jump detected → `jump_target`; else `pc_plus4`.
- IF/ID update in RUN:
  - `branch_taken`: `if_id_valid` ← 0 (flush wrong-path word), `if_id_instr` ← 32'h0, `fetch_count` unchanged. Branch overrides `stall`.
  - `stall` (no branch): IF/ID, `fetch_count` hold.
  - otherwise: `if_id_instr` ← `instr_in`, `if_id_pc_plus4` ← `pc_plus4`, `if_id_valid` ← 1, `fetch_count` += 1 (wraps).
- Jump instruction itself is passed to IF/ID as valid; no delay slot — word after the jump is never fetched.
- Fault (evaluated on the selected next PC, only when it would be loaded): next_pc[1:0] ≠ 0, or next_pc >> 2 > IMEM_SIZE-1. On fault: PC not updated, state ← HALT, `if_id_valid` ← 0, `halted` ← 1. The instruction at current PC is still captured if the cycle would otherwise load IF/ID.
- HALT: PC, IF/ID data, `fetch_count` frozen; `if_id_valid` = 0; `stall`/`branch_taken` ignored.

## Timing
- Reset values: `pc_out` = RESET_PC, `if_id_instr` = 0, `if_id_pc_plus4` = 0, `if_id_valid` = 0, `halted` = 0, `fetch_count` = 0, state RUN.
- Memory read is combinational: `instr_in` valid in the same cycle as `pc_out`.
- Latency: word at PC appears on `if_id_*` one cycle after `pc_out` presents it.
- Jump penalty 0 cycles; taken-branch penalty = 1 flushed slot.
- `reset` asserted mid-operation (any state, including concurrent `branch_taken`/`stall`) wins; all registers return to reset values next edge.

## Structure
- Shared package `mips_pkg`: `OP_J` = 6'b000010, `NOP_WORD` = 32'h0, fetch state enum {RUN, HALT}.
- One combinational sub-module `fetch_next_pc`: inputs pc, instr, stall, branch_taken, branch_target, IMEM_SIZE; outputs next_pc, is_jump, fault. Top holds registers and FSM.

## Test plan
- Reset then run, memory holds 00011020, 00642820, ae010000, 8e040000, 20310099 at words 0-4 → `pc_out` 0,4,8,C,10 on consecutive cycles; `if_id_instr` follows one cycle later, `fetch_count`=5.
- Word 5 = 08000008 at PC 0x14 → next `pc_out` = 0x20; IF/ID holds 08000008 with `if_id_pc_plus4`=0x18, `valid`=1; 0x18 never fetched.
- At PC 0x20, `branch_taken`=1, `branch_target`=0x28 together with `stall`=1 → `pc_out`=0x28 next cycle, `if_id_valid`=0, `fetch_count` unchanged.
- `stall` held 3 cycles at PC 0x8 → `pc_out`, `if_id_*`, `fetch_count` constant; release → resumes at 0x8 → 0xC.
- `branch_target`=0x202 (misaligned) and separately 0x200 (word 128) → `halted`=1, `if_id_valid`=0, PC frozen; further inputs ignored.
- From HALT or mid-stream, pulse `reset` 1 cycle → all outputs reset values, `pc_out`=RESET_PC, fetch restarts.
